// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word and memory-stage state types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} memstate_t;
endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: holds a dmem request until dhit, stalls the pipeline, captures load data
module mem_access_ctrl
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  memread_i,
  input  logic  memwrite_i,
  input  word_t addr_i,
  input  word_t store_i,
  input  logic  halt_i,
  input  logic  flush_i,
  input  logic  dhit,
  input  word_t dmemload,
  output logic  dmemREN,
  output logic  dmemWEN,
  output word_t dmemaddr,
  output word_t dmemstore,
  output logic  mem_stall_o,
  output word_t dmemload_o,
  output logic  mem_done_o,
  output logic  wb_valid_o,
  output logic  halt_o,
  output logic  timeout_o,
  output logic  conflict_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  memstate_t   r_state;
  memstate_t   w_next;
  logic        w_req;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic        r_wr, r_kill, r_ren, r_wen, r_halt, r_timeout, r_conflict;
  word_t       r_addr, r_store, r_load;
  // next state, stall and completion outputs
  always_comb begin
    w_req       = (memread_i | memwrite_i) & ~flush_i & ~r_halt;
    w_next      = r_state;
    mem_stall_o = 1'b0;
    mem_done_o  = 1'b0;
    wb_valid_o  = 1'b0;
    w_cnt_inc   = (r_cnt == CW'(TIMEOUT_CYCLES)) ? r_cnt : r_cnt + 1'b1;
    case (r_state)
      IDLE: begin
        mem_stall_o = w_req;
        w_next      = w_req ? ACCESS : IDLE;
      end
      ACCESS: begin
        mem_stall_o = 1'b1;
        w_next      = dhit ? DONE : ACCESS;
      end
      DONE: begin
        mem_done_o = 1'b1;
        wb_valid_o = ~r_kill & ~flush_i;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  // state, held request, captured load word, timeout counter and sticky flags
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_wr       <= 1'b0;
      r_kill     <= 1'b0;
      r_ren      <= 1'b0;
      r_wen      <= 1'b0;
      r_halt     <= 1'b0;
      r_timeout  <= 1'b0;
      r_conflict <= 1'b0;
      r_addr     <= '0;
      r_store    <= '0;
      r_load     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (halt_i & ~flush_i) r_halt <= 1'b1;
          if (w_req) begin
            r_addr  <= addr_i;
            r_store <= store_i;
            r_wr    <= memwrite_i;
            r_ren   <= ~memwrite_i;
            r_wen   <= memwrite_i;
            r_kill  <= 1'b0;
            if (memread_i & memwrite_i) r_conflict <= 1'b1;
          end
        end
        ACCESS: begin
          if (flush_i) r_kill <= 1'b1;
          if (dhit) begin
            r_ren <= 1'b0;
            r_wen <= 1'b0;
            if (!r_wr) r_load <= dmemload;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == CW'(TIMEOUT_CYCLES)) r_timeout <= 1'b1;
          end
        end
        DONE: r_cnt <= '0;
        default: ;
      endcase
    end
  end
  assign dmemREN    = r_ren;
  assign dmemWEN    = r_wen;
  assign dmemaddr   = r_addr;
  assign dmemstore  = r_store;
  assign dmemload_o = r_load;
  assign halt_o     = r_halt;
  assign timeout_o  = r_timeout;
  assign conflict_o = r_conflict;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized checks against a transaction-level model
module tb_mem_access_ctrl;
  localparam int T = 4;
  logic        CLK = 1'b0, nRST = 1'b0;
  logic        memread_i, memwrite_i, halt_i, flush_i, dhit;
  logic [31:0] addr_i, store_i, dmemload;
  logic        dmemREN, dmemWEN, mem_stall_o, mem_done_o, wb_valid_o, halt_o, timeout_o, conflict_o;
  logic [31:0] dmemaddr, dmemstore, dmemload_o;
  int total = 0, bad = 0;
  bit m_known, m_pending, m_finish, m_wr, m_killed, m_halt, m_to, m_conf;
  logic [31:0] m_addr, m_data, m_load;
  int m_waits;

  mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .nRST(nRST), .memread_i(memread_i), .memwrite_i(memwrite_i),
    .addr_i(addr_i), .store_i(store_i), .halt_i(halt_i), .flush_i(flush_i),
    .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall_o(mem_stall_o),
    .dmemload_o(dmemload_o), .mem_done_o(mem_done_o), .wb_valid_o(wb_valid_o),
    .halt_o(halt_o), .timeout_o(timeout_o), .conflict_o(conflict_o)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] s,
                       input bit h, input bit f, input bit k, input logic [31:0] ld);
    nRST = 1'b1;
    memread_i = rd;
    memwrite_i = wr;
    addr_i = a;
    store_i = s;
    halt_i = h;
    flush_i = f;
    dhit = k;
    dmemload = ld;
  endtask

  task automatic tick();
    bit req;
    @(negedge CLK);
    req = (memread_i | memwrite_i) & ~flush_i & ~m_halt;
    if (m_known) begin
      check("stall", 32'(mem_stall_o), 32'(!m_finish && (m_pending || req)));
      check("ren", 32'(dmemREN), 32'(m_pending && !m_wr));
      check("wen", 32'(dmemWEN), 32'(m_pending && m_wr));
      check("addr", dmemaddr, m_addr);
      check("store", dmemstore, m_data);
      check("done", 32'(mem_done_o), 32'(m_finish));
      check("wbv", 32'(wb_valid_o), 32'(m_finish && !m_killed && !flush_i));
      check("load", dmemload_o, m_load);
      check("halt", 32'(halt_o), 32'(m_halt));
      check("timeout", 32'(timeout_o), 32'(m_to));
      check("conflict", 32'(conflict_o), 32'(m_conf));
    end
    @(posedge CLK);
    if (!nRST) begin
      m_known = 1; m_pending = 0; m_finish = 0; m_wr = 0; m_killed = 0;
      m_halt = 0; m_to = 0; m_conf = 0; m_addr = 0; m_data = 0; m_load = 0; m_waits = 0;
    end else if (m_finish) begin
      m_finish = 0;
      m_waits = 0;
    end else if (m_pending) begin
      if (flush_i) m_killed = 1;
      if (dhit) begin
        m_pending = 0;
        m_finish = 1;
        if (!m_wr) m_load = dmemload;
      end else begin
        m_waits = (m_waits < T) ? m_waits + 1 : T;
        if (m_waits == T) m_to = 1;
      end
    end else begin
      if (halt_i && !flush_i) m_halt = 1;
      if (req) begin
        m_pending = 1;
        m_wr = memwrite_i;
        m_addr = addr_i;
        m_data = store_i;
        m_killed = 0;
        if (memread_i && memwrite_i) m_conf = 1;
      end
    end
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b0;
    tick();
    tick();
    drive(1, 0, 32'h100, 0, 0, 0, 0, 0);
    tick();
    tick();
    nRST = 1'b0;
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 32'h55);
    tick();
    check("rst_ren", 32'(dmemREN), 0);
    check("rst_addr", dmemaddr, 0);
    check("rst_load", dmemload_o, 0);
    drive(1, 0, 32'h40, 0, 0, 0, 0, 0);
    repeat (3) tick();
    drive(1, 0, 32'h40, 0, 0, 0, 1, 32'hDEADBEEF);
    tick();
    drive(1, 0, 32'h40, 0, 0, 0, 0, 0);
    tick();
    check("ld_data", dmemload_o, 32'hDEADBEEF);
    drive(0, 1, 32'h80, 32'h12345678, 0, 0, 0, 0);
    tick();
    drive(0, 1, 32'h80, 32'h12345678, 0, 0, 1, 32'h1111);
    tick();
    tick();
    check("st_addr", dmemaddr, 32'h80);
    check("st_data", dmemstore, 32'h12345678);
    check("st_load", dmemload_o, 32'hDEADBEEF);
    drive(1, 0, 32'hC0, 0, 0, 0, 0, 0);
    tick();
    tick();
    drive(1, 0, 32'hC0, 0, 0, 1, 0, 0);
    tick();
    drive(1, 0, 32'hC0, 0, 0, 0, 1, 32'h77);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 32'h200, 0, 0, 1, 0, 0);
    tick();
    tick();
    check("fl_idle_ren", 32'(dmemREN), 0);
    drive(1, 0, 32'h300, 0, 0, 0, 0, 0);
    repeat (6) tick();
    check("to_flag", 32'(timeout_o), 1);
    check("to_ren", 32'(dmemREN), 1);
    drive(1, 0, 32'h300, 0, 0, 0, 1, 32'hA5A5A5A5);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("to_load", dmemload_o, 32'hA5A5A5A5);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    drive(1, 0, 32'h400, 0, 0, 0, 0, 0);
    repeat (4) tick();
    check("halt_flag", 32'(halt_o), 1);
    check("halt_ren", 32'(dmemREN), 0);
    nRST = 1'b0;
    tick();
    drive(1, 1, 32'h500, 32'hCAFE, 0, 0, 0, 0);
    tick();
    check("cf_wen", 32'(dmemWEN), 1);
    check("cf_ren", 32'(dmemREN), 0);
    check("cf_flag", 32'(conflict_o), 1);
    drive(1, 1, 32'h500, 32'hCAFE, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    repeat (3000) begin
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, $urandom, $urandom,
            $urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 2) == 0, $urandom);
      nRST = $urandom_range(0, 99) != 0;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
